// File: rtl/ram1_arbiter.sv
// rtl/ram1_arbiter.sv - RAM1 SRAM bus arbiter between instruction fetch and data ports.
// Optional macro RAM1_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed D priority.
module ram1_arbiter #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [1:0] BANK        = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        conflict,
    output logic        busy,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_drive,
    input  logic [15:0] ram_din,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        owner_d, owner_nxt;
    logic        wr_q, wr_nxt;
    logic        last_grant_d, last_nxt;
    logic        grant_d;

    logic [17:0] addr_nxt;
    logic [15:0] dout_nxt;
    logic        drive_nxt;
    logic        en_nxt;
    logic        oe_nxt;
    logic        we_nxt;
    logic [15:0] if_rdata_nxt;
    logic [15:0] d_rdata_nxt;
    logic        if_ack_nxt;
    logic        d_ack_nxt;

    assign conflict = if_req & d_req & (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            owner_d      <= 1'b0;
            wr_q         <= 1'b0;
            last_grant_d <= 1'b0;
            ram_addr     <= {BANK, 16'h0000};
            ram_dout     <= 16'h0000;
            ram_drive    <= 1'b0;
            ram_en_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            if_rdata     <= 16'h0000;
            d_rdata      <= 16'h0000;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            owner_d      <= owner_nxt;
            wr_q         <= wr_nxt;
            last_grant_d <= last_nxt;
            ram_addr     <= addr_nxt;
            ram_dout     <= dout_nxt;
            ram_drive    <= drive_nxt;
            ram_en_n     <= en_nxt;
            ram_oe_n     <= oe_nxt;
            ram_we_n     <= we_nxt;
            if_rdata     <= if_rdata_nxt;
            d_rdata      <= d_rdata_nxt;
            if_ack       <= if_ack_nxt;
            d_ack        <= d_ack_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        owner_nxt    = owner_d;
        wr_nxt       = wr_q;
        last_nxt     = last_grant_d;
        addr_nxt     = ram_addr;
        dout_nxt     = ram_dout;
        drive_nxt    = ram_drive;
        en_nxt       = ram_en_n;
        oe_nxt       = ram_oe_n;
        we_nxt       = ram_we_n;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;

`ifdef RAM1_ARB_ROUND_ROBIN_EN
        // On a tie, hand the bus to whichever port did not win last time.
        grant_d = d_req & (~if_req | ~last_grant_d);
`else
        grant_d = d_req;
`endif

        unique case (state)
            IDLE: begin
                if (d_req | if_req) begin
                    owner_nxt = grant_d;
                    wr_nxt    = grant_d & d_we;
                    addr_nxt  = {BANK, (grant_d ? d_addr : if_addr)};
                    en_nxt    = 1'b0;
                    cnt_nxt   = 3'd0;
                    state_nxt = ACCESS;
                    if (grant_d & d_we) begin
                        drive_nxt = 1'b1;
                        dout_nxt  = d_wdata;
                        oe_nxt    = 1'b1;
                        we_nxt    = 1'b0;
                    end else begin
                        drive_nxt = 1'b0;
                        oe_nxt    = 1'b0;
                        we_nxt    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    if (!wr_q) begin
                        if (owner_d) d_rdata_nxt  = ram_din;
                        else         if_rdata_nxt = ram_din;
                    end
                    // Address stays latched through DONE so the write sees stable address at WE rise.
                    we_nxt     = 1'b1;
                    oe_nxt     = 1'b1;
                    en_nxt     = 1'b1;
                    drive_nxt  = 1'b0;
                    d_ack_nxt  = owner_d;
                    if_ack_nxt = ~owner_d;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DONE: begin
                last_nxt  = owner_d;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram1_arbiter.sv
// tb/tb_ram1_arbiter.sv - scoreboard bench for ram1_arbiter (WAIT_CYCLES=1 and WAIT_CYCLES=3 instances).
module tb_ram1_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [15:0] d_wdata = 16'h0;

    logic [15:0] if_rdata, d_rdata, ram_dout, ram_din;
    logic        if_ack, d_ack, conflict, busy, ram_drive, ram_en_n, ram_oe_n, ram_we_n;
    logic [17:0] ram_addr;

    logic [15:0] if_rdata3, d_rdata3, ram_dout3, ram_din3;
    logic        if_ack3, d_ack3, conflict3, busy3, ram_drive3, ram_en_n3, ram_oe_n3, ram_we_n3;
    logic [17:0] ram_addr3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit d_persist = 1'b0;

    typedef struct {
        logic        is_d;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    logic [15:0] exp_d_rdata = 16'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sram_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h4F01 : (a ^ 16'hA5A5);
    endfunction

    assign ram_din  = sram_word(ram_addr[15:0]);
    assign ram_din3 = sram_word(ram_addr3[15:0]);

    ram1_arbiter #(.WAIT_CYCLES(1), .BANK(2'b00)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .conflict(conflict), .busy(busy),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_drive(ram_drive), .ram_din(ram_din),
        .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    ram1_arbiter #(.WAIT_CYCLES(3), .BANK(2'b00)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ack(if_ack3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_ack(d_ack3), .conflict(conflict3), .busy(busy3),
        .ram_addr(ram_addr3), .ram_dout(ram_dout3), .ram_drive(ram_drive3), .ram_din(ram_din3),
        .ram_en_n(ram_en_n3), .ram_oe_n(ram_oe_n3), .ram_we_n(ram_we_n3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the WAIT_CYCLES=1 instance; also plays the requester dropping req on ack.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (if_ack || d_ack)) begin
            check("ack_exclusive", {31'd0, if_ack & d_ack}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, e.is_d});
                check("ack_cycle", cyc, e.due);
                check("rdata", {16'd0, (e.is_d ? d_rdata : if_rdata)}, {16'd0, e.data});
            end
            if (if_ack) if_req = 1'b0;
            if (d_ack && !d_persist) d_req = 1'b0;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!if_req && !d_req && !busy && !busy3) return;
            @(negedge clk);
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic push(input logic is_d, input logic [15:0] data, input int due);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.due  = due;
        sb.push_back(e);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_en_n", {31'd0, ram_en_n}, 32'd1);
        check("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
        check("rst_we_n", {31'd0, ram_we_n}, 32'd1);
        check("rst_drive", {31'd0, ram_drive}, 32'd0);
        check("rst_addr", {14'd0, ram_addr}, 32'h0);
        check("rst_rdata", {if_rdata, d_rdata}, 32'h0);
        check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // IF read, WAIT_CYCLES=1
        @(negedge clk);
        c = cyc;
        if_addr = 16'h0010; if_req = 1'b1;
        push(1'b0, 16'h4F01, c + 2);
        @(negedge clk);
        check("rd_addr", {14'd0, ram_addr}, 32'h00010);
        check("rd_oe_n", {31'd0, ram_oe_n}, 32'd0);
        check("rd_en_n", {31'd0, ram_en_n}, 32'd0);
        wait_idle();

        // Conflict: D first, IF two accesses later
        c = cyc;
        if_addr = 16'h0020; d_addr = 16'h0030; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        check("conflict", {31'd0, conflict}, 32'd1);
        push(1'b1, sram_word(16'h0030), c + 2);
        push(1'b0, sram_word(16'h0020), c + 5);
        exp_d_rdata = sram_word(16'h0030);
        @(negedge clk);
        check("conflict_busy", {30'd0, conflict, busy}, 32'd1);
        wait_idle();

        // Continuous d_req against a waiting IF request
        c = cyc;
        if_addr = 16'h0200; d_addr = 16'h0100;
        d_persist = 1'b1; if_req = 1'b1; d_req = 1'b1;
        exp_d_rdata = sram_word(16'h0100);
`ifdef RAM1_ARB_ROUND_ROBIN_EN
        push(1'b1, exp_d_rdata, c + 2);
        push(1'b0, sram_word(16'h0200), c + 5);
        push(1'b1, exp_d_rdata, c + 8);
`else
        push(1'b1, exp_d_rdata, c + 2);
        push(1'b1, exp_d_rdata, c + 5);
        push(1'b1, exp_d_rdata, c + 8);
        push(1'b0, sram_word(16'h0200), c + 11);
`endif
        repeat (6) @(negedge clk);
        d_persist = 1'b0;
        wait_idle();

        // D write
        c = cyc;
        d_addr = 16'h8000; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
        push(1'b1, exp_d_rdata, c + 2);
        check("wr_we_pre", {31'd0, ram_we_n}, 32'd1);
        @(negedge clk);
        check("wr_we_low", {31'd0, ram_we_n}, 32'd0);
        check("wr_drive", {31'd0, ram_drive}, 32'd1);
        check("wr_dout", {16'd0, ram_dout}, 32'hBEEF);
        check("wr_addr", {14'd0, ram_addr}, 32'h08000);
        check("wr_oe_n", {31'd0, ram_oe_n}, 32'd1);
        @(negedge clk);
        check("wr_we_done", {31'd0, ram_we_n}, 32'd1);
        check("wr_drive_done", {31'd0, ram_drive}, 32'd0);
        d_we = 1'b0;
        wait_idle();

        // D read at top of address space
        c = cyc;
        d_addr = 16'hFFFF; d_we = 1'b0; d_req = 1'b1;
        exp_d_rdata = sram_word(16'hFFFF);
        push(1'b1, exp_d_rdata, c + 2);
        @(negedge clk);
        check("wrap_addr", {14'd0, ram_addr}, 32'h0FFFF);
        wait_idle();

        // Reset in the middle of an IF read
        if_addr = 16'h0044; if_req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {30'd0, if_ack, d_ack}, 32'd0);
        check("mid_rst_strobes", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'd7);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdata", {16'd0, if_rdata}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_idle();

        // WAIT_CYCLES=3 read on the second instance
        c = cyc;
        if_addr = 16'h0033; if_req = 1'b1;
        push(1'b0, sram_word(16'h0033), c + 2);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("w3_oe_low", {31'd0, ram_oe_n3}, 32'd0);
            check("w3_no_ack", {31'd0, if_ack3}, 32'd0);
        end
        check("w3_rdata_pre", {16'd0, if_rdata3}, 32'd0);
        @(negedge clk);
        check("w3_ack", {31'd0, if_ack3}, 32'd1);
        check("w3_rdata", {16'd0, if_rdata3}, {16'd0, sram_word(16'h0033)});
        check("w3_oe_done", {31'd0, ram_oe_n3}, 32'd1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
